sample_ring_reader: RTL
=======================

Name: sample_ring_reader

Overview:
- Drains the ADC sample ring buffer in RAM, in write order.
- The ADC capture side writes each sample into RAM port B and pulses `wr_pulse`.
- This block arbitrates for port B read slots, fetches each unread sample, and presents it on a valid/ready stream with its ring index.
- It sits between the RAM port B mux and downstream consumers (streaming/plot logic), and flags overruns.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width.
- DATA_WIDTH, 32, sample word width.
- BASE_ADDR, 12'hC7F, RAM word address of ring index 0.
- DEPTH, 641, ring length in samples (indices 0..DEPTH-1).
- IDX_WIDTH, 10, width of ring index/count (must hold DEPTH).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_pulse  in  1  one-cycle pulse: writer stored a new sample this cycle.
- ram_req  out  1  read request for RAM port B.
- ram_addr  out  ADDR_WIDTH  read address, valid while ram_req=1.
- ram_grant  in  1  port B read slot granted this cycle (low while the ADC write owns the port).
- ram_data  in  DATA_WIDTH  RAM port B read data, valid the cycle after a granted request.
- out_valid  out  1  out_data/out_index valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_WIDTH  sample word.
- out_index  out  IDX_WIDTH  ring index of the sample.
- level  out  IDX_WIDTH  unread samples not yet fetched.
- overrun  out  1  sticky: at least one sample was lost.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; rd_ptr=0; level=0.
  - ram_req=0; ram_addr=BASE_ADDR.
  - out_valid=0; out_data=0; out_index=0; overrun=0.
  - Reset mid-fetch abandons the fetch; ram_data arriving afterwards is ignored.
- FSM states:
  - IDLE: ram_req=0. If level>0, go to REQ.
  - REQ:
    - ram_req=1, ram_addr=(BASE_ADDR+rd_ptr) mod 2^ADDR_WIDTH.
    - ram_addr is held stable until granted.
    - If ram_grant=1: pop (level decrements), go to WAIT. Otherwise stay in REQ.
  - WAIT:
    - ram_req=0.
    - Capture ram_data into out_data and rd_ptr into out_index; set out_valid=1.
    - rd_ptr advances, wrapping DEPTH-1 to 0. Go to HOLD.
  - HOLD: hold out_* stable while out_valid=1 and out_ready=0. On out_valid&out_ready:
    - if level>0: clear out_valid and go to REQ;
    - otherwise clear out_valid and go to IDLE.
- Latency: wr_pulse in cycle 0 with an empty ring and IDLE:
  - level=1 in cycle 1;
  - ram_req=1 in cycle 2;
  - with grant in cycle 2, out_valid=1 in cycle 4;
  - each grant-denied cycle adds 1 cycle.
- Level arithmetic: next = level + wr_pulse − pop.
  - wr_pulse and pop in the same cycle: level unchanged.
- Overrun:
  - Condition: wr_pulse=1, pop=0, level==DEPTH.
  - level stays DEPTH and overrun is set.
  - rd_ptr advances by one with wrap, skipping the overwritten oldest sample.
  - In REQ, ram_addr tracks the new rd_ptr.
- Full with wr_pulse and pop together: no overrun, level unchanged.
- overrun_clr and an overrun event in the same cycle: overrun=1 (set wins).
- Throughput: at most one sample per 3 cycles (REQ, WAIT, HOLD).
- A consumer holding out_ready=0 accumulates level and may cause overrun.

Test Plan:
- Reset: hold reset=0 for 3 cycles → out_valid=0, ram_req=0, ram_addr=12'hC7F, level=0, overrun=0.
- Single sample, always-grant, out_ready=1, ram_data=32'h0000_0ABC after request:
  - wr_pulse in cycle 0 → ram_req in cycle 2 with ram_addr=12'hC7F;
  - out_valid in cycle 4 with out_data=32'h0ABC, out_index=0;
  - then IDLE, level=0.
- Grant stall: 3 samples pending, ram_grant=0 for 5 cycles → ram_req=1 with ram_addr=12'hC7F held stable throughout; after grant, samples at 12'hC7F, 12'hC80, 12'hC81 emerge in order with index 0, 1, 2.
- Wrap: preload rd_ptr to 640 via 640 prior writes/reads → the next fetch uses ram_addr=12'hC7F+640=12'hEFF, index 640; the following fetch uses 12'hC7F, index 0.
- Overrun: out_ready=0, issue 643 wr_pulses →
  - level saturates at 641;
  - overrun=1 after the sample that first exceeds capacity;
  - overrun_clr pulse with no concurrent wr_pulse → overrun=0.
- Backpressure: out_valid=1 with out_ready=0 for 10 cycles → out_data and out_index constant; a wr_pulse in that window increments level by 1.

Source files
------------

// File: rtl/sample_ring_reader.sv
// Drains the ADC sample ring in RAM in write order. It fetches each unread sample over
// RAM port B and presents it on a valid/ready stream tagged with its ring index.
module sample_ring_reader #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 12'hC7F,
  parameter int                    DEPTH      = 641,
  parameter int                    IDX_WIDTH  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_pulse,
  output logic                  ram_req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_grant,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic [IDX_WIDTH-1:0]  level,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [IDX_WIDTH-1:0] DEPTH_IDX = IDX_WIDTH'(DEPTH);

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDX_WIDTH-1:0]  level_q, level_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [IDX_WIDTH-1:0]  out_index_q;
  logic                  overrun_q;
  logic                  pop;
  logic                  ovr_evt;
  logic [1:0]            ptr_step;

  // Ring-pointer advance by 0..2 with wrap at DEPTH; p is always below DEPTH.
  function automatic logic [IDX_WIDTH-1:0] ptr_advance(input logic [IDX_WIDTH-1:0] p,
                                                       input logic [1:0]           n);
    logic [IDX_WIDTH:0] s;
    s = {1'b0, p} + (IDX_WIDTH+1)'(n);
    if (s >= (IDX_WIDTH+1)'(DEPTH))
      s = s - (IDX_WIDTH+1)'(DEPTH);
    return s[IDX_WIDTH-1:0];
  endfunction

  assign pop     = (state_q == REQ) && ram_grant;
  assign ovr_evt = wr_pulse && !pop && (level_q == DEPTH_IDX);

  // A capture and an overrun skip can land in the same cycle, so the pointer may step by two.
  always_comb begin
    ptr_step = 2'(state_q == WAIT) + 2'(ovr_evt);
    rd_ptr_d = ptr_advance(rd_ptr_q, ptr_step);
  end

  always_comb begin
    level_d = level_q;
    if (ovr_evt)
      level_d = level_q;
    else if (wr_pulse && !pop)
      level_d = level_q + IDX_WIDTH'(1);
    else if (!wr_pulse && pop)
      level_d = level_q - IDX_WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (level_q != '0) state_d = REQ;
      REQ:  if (ram_grant) state_d = WAIT;
      WAIT: state_d = HOLD;
      HOLD: if (out_valid_q && out_ready) state_d = (level_q != '0) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (ovr_evt)
        overrun_q <= 1'b1;
      else if (overrun_clr)
        overrun_q <= 1'b0;
    end
  end

  // Output stage: RAM read data lands here the cycle after the granted request.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else if (state_q == WAIT) begin
      out_valid_q <= 1'b1;
      out_data_q  <= ram_data;
      out_index_q <= rd_ptr_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign ram_req   = (state_q == REQ);
  assign ram_addr  = BASE_ADDR + ADDR_WIDTH'(rd_ptr_q);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign level     = level_q;
  assign overrun   = overrun_q;

endmodule
